// File: rtl/remote_update_pkg.sv
// Shared encodings for the remote-update command sequencer.
package remote_update_pkg;

   typedef enum logic [1:0] {
      OP_READ        = 2'd0,
      OP_WRITE       = 2'd1,
      OP_RECONFIG    = 2'd2,
      OP_RESET_TIMER = 2'd3
   } ru_op_e;

   // Parameter 0 of the core is the read-only status register.
   localparam logic [2:0] STATUS_PARAM = 3'b000;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT_HI,
      ST_WAIT_LO,
      ST_RESP,
      ST_RT_PULSE,
      ST_HALT
   } ru_state_e;

endpackage

// File: rtl/ru_cycle_counter.sv
// Loadable saturating down-counter; done while the count sits at zero.
module ru_cycle_counter
   import remote_update_pkg::*;
#(
   parameter int unsigned WIDTH = 13
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   output logic [WIDTH-1:0] count,
   output logic             done
);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         count <= '0;
      end else if (load) begin
         count <= load_value;
      end else if (count != '0) begin
         count <= count - 1'b1;
      end
   end

   assign done = (count == '0);

endmodule

// File: rtl/remote_update_ctrl.sv
// Sequences host read/write/reconfig/watchdog commands onto the
// remote-update core strobe/busy handshake and returns a one-cycle response.
module remote_update_ctrl
   import remote_update_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES  = 4096,
   parameter int unsigned BUSY_RISE_MAX   = 4,
   parameter int unsigned RT_PULSE_CYCLES = 32,
   parameter logic [31:0] RECONFIG_KEY    = 32'h5EC0_F16A
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [1:0]  cmd_op,
   input  logic [2:0]  cmd_param,
   input  logic        cmd_ctl,
   input  logic [31:0] cmd_wdata,
   output logic        rsp_valid,
   output logic        rsp_err,
   output logic [31:0] rsp_rdata,
   output logic        ru_read_param,
   output logic        ru_write_param,
   output logic        ru_reconfig,
   output logic        ru_reset_timer,
   output logic [2:0]  ru_param,
   output logic [31:0] ru_data_in,
   output logic        ru_ctl_nupdt,
   input  logic        ru_busy,
   input  logic [31:0] ru_data_out
);

   localparam int unsigned CNT_MAX = (TIMEOUT_CYCLES > RT_PULSE_CYCLES) ?
                                     TIMEOUT_CYCLES : RT_PULSE_CYCLES;
   localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

   localparam logic [CNT_W-1:0] BUSY_LOAD = CNT_W'(BUSY_RISE_MAX - 1);
   localparam logic [CNT_W-1:0] RT_LOAD   = CNT_W'(RT_PULSE_CYCLES - 1);
   localparam logic [CNT_W-1:0] LO_BIAS   = CNT_W'(TIMEOUT_CYCLES - BUSY_RISE_MAX - 1);

   ru_state_e        state;
   ru_op_e           op_q;
   ru_op_e           cmd_op_e;
   logic             idle_q;
   logic             accept;
   logic             cnt_load;
   logic [CNT_W-1:0] cnt_value;
   logic [CNT_W-1:0] cnt_count;
   logic             cnt_done;

   assign cmd_op_e  = ru_op_e'(cmd_op);
   assign cmd_ready = idle_q & ~ru_busy;
   assign accept    = cmd_ready & cmd_valid;

   // During the busy-rise wait the count equals BUSY_RISE_MAX minus the cycle
   // index since accept, so reloading with count + LO_BIAS leaves the single
   // counter expiring exactly TIMEOUT_CYCLES cycles after the ISSUE cycle.
   always_comb begin
      cnt_load  = 1'b0;
      cnt_value = '0;
      case (state)
         ST_IDLE: begin
            if (accept) begin
               cnt_load  = 1'b1;
               cnt_value = (cmd_op_e == OP_RESET_TIMER) ? RT_LOAD : BUSY_LOAD;
            end
         end
         ST_WAIT_HI: begin
            if (ru_busy) begin
               cnt_load  = 1'b1;
               cnt_value = cnt_count + LO_BIAS;
            end
         end
         default: ;
      endcase
   end

   ru_cycle_counter #(
      .WIDTH(CNT_W)
   ) u_counter (
      .clock     (clock),
      .reset_n   (reset_n),
      .load      (cnt_load),
      .load_value(cnt_value),
      .count     (cnt_count),
      .done      (cnt_done)
   );

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state          <= ST_IDLE;
         op_q           <= OP_READ;
         idle_q         <= 1'b0;
         rsp_valid      <= 1'b0;
         rsp_err        <= 1'b0;
         rsp_rdata      <= '0;
         ru_read_param  <= 1'b0;
         ru_write_param <= 1'b0;
         ru_reconfig    <= 1'b0;
         ru_reset_timer <= 1'b0;
         ru_param       <= '0;
         ru_data_in     <= '0;
         ru_ctl_nupdt   <= 1'b0;
      end else begin
         idle_q         <= 1'b0;
         rsp_valid      <= 1'b0;
         ru_read_param  <= 1'b0;
         ru_write_param <= 1'b0;
         ru_reconfig    <= 1'b0;
         case (state)
            ST_IDLE: begin
               idle_q <= 1'b1;
               if (accept) begin
                  idle_q       <= 1'b0;
                  op_q         <= cmd_op_e;
                  ru_param     <= cmd_param;
                  ru_ctl_nupdt <= cmd_ctl;
                  ru_data_in   <= cmd_wdata;
                  case (cmd_op_e)
                     OP_READ: begin
                        state         <= ST_ISSUE;
                        ru_read_param <= 1'b1;
                     end
                     OP_WRITE: begin
                        if (cmd_param == STATUS_PARAM) begin
                           state     <= ST_RESP;
                           rsp_valid <= 1'b1;
                           rsp_err   <= 1'b1;
                        end else begin
                           state          <= ST_ISSUE;
                           ru_write_param <= 1'b1;
                        end
                     end
                     OP_RECONFIG: begin
                        if (cmd_wdata != RECONFIG_KEY) begin
                           state     <= ST_RESP;
                           rsp_valid <= 1'b1;
                           rsp_err   <= 1'b1;
                        end else begin
                           state       <= ST_ISSUE;
                           ru_reconfig <= 1'b1;
                        end
                     end
                     OP_RESET_TIMER: begin
                        state          <= ST_RT_PULSE;
                        ru_reset_timer <= 1'b1;
                     end
                  endcase
               end
            end
            ST_ISSUE: begin
               state <= (op_q == OP_RECONFIG) ? ST_HALT : ST_WAIT_HI;
            end
            ST_WAIT_HI: begin
               if (ru_busy) begin
                  state <= ST_WAIT_LO;
               end else if (cnt_done) begin
                  state     <= ST_RESP;
                  rsp_valid <= 1'b1;
                  rsp_err   <= 1'b1;
               end
            end
            ST_WAIT_LO: begin
               if (!ru_busy) begin
                  state     <= ST_RESP;
                  rsp_valid <= 1'b1;
                  rsp_err   <= 1'b0;
                  if (op_q == OP_READ) begin
                     rsp_rdata <= ru_data_out;
                  end
               end else if (cnt_done) begin
                  state     <= ST_RESP;
                  rsp_valid <= 1'b1;
                  rsp_err   <= 1'b1;
                  rsp_rdata <= '0;
               end
            end
            ST_RESP: begin
               state  <= ST_IDLE;
               idle_q <= 1'b1;
            end
            ST_RT_PULSE: begin
               if (cnt_done) begin
                  state          <= ST_RESP;
                  ru_reset_timer <= 1'b0;
                  rsp_valid      <= 1'b1;
                  rsp_err        <= 1'b0;
               end
            end
            ST_HALT: ;
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_remote_update_ctrl.sv
// Directed-vector bench for remote_update_ctrl with a cycle-indexed busy model.
module tb_remote_update_ctrl;
   import remote_update_pkg::*;

   localparam int unsigned TMO  = 4096;
   localparam int          NONE = 1000000;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [1:0]  cmd_op = '0;
   logic [2:0]  cmd_param = '0;
   logic        cmd_ctl = 1'b0;
   logic [31:0] cmd_wdata = '0;
   logic        rsp_valid, rsp_err;
   logic [31:0] rsp_rdata;
   logic        ru_read_param, ru_write_param, ru_reconfig, ru_reset_timer;
   logic [2:0]  ru_param;
   logic [31:0] ru_data_in;
   logic        ru_ctl_nupdt;
   logic        ru_busy = 1'b0;
   logic [31:0] ru_data_out = '0;

   int          n_vec = 0;
   int          n_bad = 0;
   int          rsp_cyc, rd_cnt, rd_first, wr_cnt, rc_cnt, rc_first;
   int          rt_cnt, rt_first, rt_last, oper_bad;
   logic        got_err, after_valid, after_ready;
   logic [31:0] got_rdata;

   always #5 clock = ~clock;

   remote_update_ctrl #(
      .TIMEOUT_CYCLES (TMO),
      .BUSY_RISE_MAX  (4),
      .RT_PULSE_CYCLES(32),
      .RECONFIG_KEY   (32'h5EC0_F16A)
   ) dut (
      .clock         (clock),
      .reset_n       (reset_n),
      .cmd_valid     (cmd_valid),
      .cmd_ready     (cmd_ready),
      .cmd_op        (cmd_op),
      .cmd_param     (cmd_param),
      .cmd_ctl       (cmd_ctl),
      .cmd_wdata     (cmd_wdata),
      .rsp_valid     (rsp_valid),
      .rsp_err       (rsp_err),
      .rsp_rdata     (rsp_rdata),
      .ru_read_param (ru_read_param),
      .ru_write_param(ru_write_param),
      .ru_reconfig   (ru_reconfig),
      .ru_reset_timer(ru_reset_timer),
      .ru_param      (ru_param),
      .ru_data_in    (ru_data_in),
      .ru_ctl_nupdt  (ru_ctl_nupdt),
      .ru_busy       (ru_busy),
      .ru_data_out   (ru_data_out)
   );

   task automatic check_vec(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic check_zero(input string tag);
      check_vec({tag, "_data"}, {rsp_rdata, ru_data_in}, '0);
      check_vec({tag, "_ctl"}, 64'({cmd_ready, rsp_valid, rsp_err, ru_read_param, ru_write_param,
                                    ru_reconfig, ru_reset_timer, ru_param, ru_ctl_nupdt}), '0);
   endtask

   // Cycle 0 presents the command; ru_busy is high for cycles busy_lo..busy_hi.
   task automatic run_cmd(input string tag, input logic [1:0] op, input logic [2:0] param,
                          input logic ctl, input logic [31:0] wdata,
                          input int busy_lo, input int busy_hi, input int limit);
      rsp_cyc = -1; rd_cnt = 0; rd_first = -1; wr_cnt = 0; rc_cnt = 0; rc_first = -1;
      rt_cnt = 0; rt_first = -1; rt_last = -1; oper_bad = 0;
      @(posedge clock); #1;
      cmd_valid = 1'b1; cmd_op = op; cmd_param = param; cmd_ctl = ctl; cmd_wdata = wdata;
      ru_busy = 1'b0;
      @(negedge clock);
      check_vec({tag, "_ready"}, cmd_ready, 1);
      for (int c = 1; c <= limit && rsp_cyc < 0; c++) begin
         @(posedge clock); #1;
         cmd_valid = 1'b0;
         ru_busy = (c >= busy_lo && c <= busy_hi);
         @(negedge clock);
         if (ru_read_param) begin rd_cnt++; if (rd_first < 0) rd_first = c; end
         if (ru_write_param) wr_cnt++;
         if (ru_reconfig) begin rc_cnt++; if (rc_first < 0) rc_first = c; end
         if (ru_reset_timer) begin rt_cnt++; if (rt_first < 0) rt_first = c; rt_last = c; end
         if (ru_param !== param || ru_data_in !== wdata || ru_ctl_nupdt !== ctl) oper_bad++;
         if (rsp_valid) begin
            rsp_cyc = c; got_err = rsp_err; got_rdata = rsp_rdata;
         end
      end
      @(posedge clock); #1;
      ru_busy = 1'b0;
      @(negedge clock);
      after_valid = rsp_valid;
      after_ready = cmd_ready;
   endtask

   initial begin
      #3;
      check_zero("por");
      @(posedge clock); #1;
      reset_n = 1'b1;
      @(negedge clock);
      @(negedge clock);
      check_vec("por_ready", cmd_ready, 1);

      ru_data_out = 32'h0000_1234;
      run_cmd("rd", OP_READ, 3'b010, 1'b1, 32'h0, 2, 5, 20);
      check_vec("rd_cyc", rsp_cyc, 7);
      check_vec("rd_err", got_err, 0);
      check_vec("rd_data", got_rdata, 32'h0000_1234);
      check_vec("rd_strobe_n", rd_cnt, 1);
      check_vec("rd_strobe_at", rd_first, 1);
      check_vec("rd_single", after_valid, 0);
      check_vec("rd_b2b_ready", after_ready, 1);

      ru_data_out = 32'h0000_BEEF;
      run_cmd("fast", OP_READ, 3'b001, 1'b0, 32'h0, 2, 2, 20);
      check_vec("fast_cyc", rsp_cyc, 4);
      check_vec("fast_data", got_rdata, 32'h0000_BEEF);

      ru_data_out = 32'h1111_1111;
      run_cmd("wr", OP_WRITE, 3'b011, 1'b0, 32'h0002_0000, 2, 3, 20);
      check_vec("wr_cyc", rsp_cyc, 5);
      check_vec("wr_err", got_err, 0);
      check_vec("wr_strobe_n", wr_cnt, 1);
      check_vec("wr_operands", oper_bad, 0);
      check_vec("wr_rdata_kept", got_rdata, 32'h0000_BEEF);

      run_cmd("rej_st", OP_WRITE, 3'b000, 1'b1, 32'hFFFF_FFFF, NONE, 0, 10);
      check_vec("rej_st_cyc", rsp_cyc, 1);
      check_vec("rej_st_err", got_err, 1);
      check_vec("rej_st_strobes", rd_cnt + wr_cnt + rc_cnt + rt_cnt, 0);
      check_vec("rej_st_rdata", got_rdata, 32'h0000_BEEF);

      run_cmd("rej_key", OP_RECONFIG, 3'b000, 1'b0, 32'h5EC0_F16B, NONE, 0, 10);
      check_vec("rej_key_cyc", rsp_cyc, 1);
      check_vec("rej_key_err", got_err, 1);
      check_vec("rej_key_strobes", rd_cnt + wr_cnt + rc_cnt + rt_cnt, 0);

      @(posedge clock); #1;
      ru_busy = 1'b1; cmd_valid = 1'b1; cmd_op = OP_READ; cmd_param = 3'b010;
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         check_vec("busy_idle_ready", cmd_ready, 0);
         check_vec("busy_idle_strobe", ru_read_param, 0);
         @(posedge clock); #1;
      end
      cmd_valid = 1'b0; ru_busy = 1'b0;

      run_cmd("norise", OP_READ, 3'b010, 1'b0, 32'h0, NONE, 0, 20);
      check_vec("norise_cyc", rsp_cyc, 5);
      check_vec("norise_err", got_err, 1);

      run_cmd("rt", OP_RESET_TIMER, 3'b000, 1'b0, 32'h0, 2, 40, 40);
      check_vec("rt_cnt", rt_cnt, 32);
      check_vec("rt_first", rt_first, 1);
      check_vec("rt_last", rt_last, 32);
      check_vec("rt_cyc", rsp_cyc, 33);
      check_vec("rt_err", got_err, 0);
      check_vec("rt_other_strobes", rd_cnt + wr_cnt + rc_cnt, 0);

      ru_data_out = 32'hCAFE_0001;
      run_cmd("stuck", OP_READ, 3'b010, 1'b0, 32'h0, 2, NONE, TMO + 50);
      check_vec("stuck_cyc", rsp_cyc, TMO + 1);
      check_vec("stuck_err", got_err, 1);
      check_vec("stuck_rdata", got_rdata, 0);

      run_cmd("late", OP_READ, 3'b010, 1'b0, 32'h0, 2, TMO, TMO + 50);
      check_vec("late_cyc", rsp_cyc, TMO + 1);
      check_vec("late_err", got_err, 1);

      run_cmd("edge", OP_READ, 3'b010, 1'b0, 32'h0, 2, TMO - 1, TMO + 50);
      check_vec("edge_cyc", rsp_cyc, TMO + 1);
      check_vec("edge_err", got_err, 0);
      check_vec("edge_rdata", got_rdata, 32'hCAFE_0001);

      @(posedge clock); #1;
      cmd_valid = 1'b1; cmd_op = OP_READ; cmd_param = 3'b101; cmd_ctl = 1'b1; cmd_wdata = 32'hA5A5;
      @(posedge clock); #1;
      cmd_valid = 1'b0;
      @(posedge clock); #1;
      ru_busy = 1'b1;
      @(posedge clock); #1;
      @(negedge clock);
      check_vec("mid_param", ru_param, 3'b101);
      #2;
      reset_n = 1'b0;
      #1;
      check_zero("mid_rst");
      for (int i = 0; i < 2; i++) begin
         @(negedge clock);
         check_vec("mid_rst_novalid", rsp_valid, 0);
      end
      @(posedge clock); #1;
      reset_n = 1'b1; ru_busy = 1'b0;
      @(negedge clock);
      @(negedge clock);
      check_vec("mid_rel_ready", cmd_ready, 1);

      ru_data_out = 32'h55AA_0000;
      run_cmd("post", OP_READ, 3'b001, 1'b0, 32'h0, 2, 3, 20);
      check_vec("post_cyc", rsp_cyc, 5);
      check_vec("post_err", got_err, 0);
      check_vec("post_data", got_rdata, 32'h55AA_0000);

      run_cmd("rcfg", OP_RECONFIG, 3'b100, 1'b1, 32'h5EC0_F16A, NONE, 0, 8);
      check_vec("rcfg_strobe_n", rc_cnt, 1);
      check_vec("rcfg_strobe_at", rc_first, 1);
      check_vec("rcfg_norsp", rsp_cyc, -1);
      check_vec("rcfg_halt_ready", after_ready, 0);
      cmd_valid = 1'b1; cmd_op = OP_READ;
      repeat (20) @(negedge clock);
      check_vec("halt_ready", cmd_ready, 0);
      check_vec("halt_nostrobe", ru_read_param, 0);
      cmd_valid = 1'b0;
      @(posedge clock); #1;
      reset_n = 1'b0;
      #1;
      check_zero("halt_rst");
      @(posedge clock); #1;
      reset_n = 1'b1;
      @(negedge clock);
      @(negedge clock);
      check_vec("halt_exit_ready", cmd_ready, 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

   initial begin
      #5ms;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "bench timeout");
   end

endmodule
